// File: rtl/rr_arb_mux_pkg.sv
// rr_arb_mux_pkg: shared defaults, statistics width and round-robin pointer helper
package rr_arb_mux_pkg;
   localparam int N_CH_DEF = 4;
   localparam int DATA_W_DEF = 8;
   localparam int STATS_W = 16;
   localparam logic [STATS_W-1:0] STATS_MAX = '1;
   function automatic int next_ptr(input int g, input int n);
      return (g == n - 1) ? 0 : g + 1;
   endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin search starting at ptr, one-hot grant gated by en
module rr_arbiter #(
   parameter int N_CH = 4,
   localparam int SEL_W = $clog2(N_CH)
) (
   input  logic [N_CH-1:0]  valid,
   input  logic [SEL_W-1:0] ptr,
   input  logic             en,
   output logic [N_CH-1:0]  gnt,
   output logic [SEL_W-1:0] gnt_idx,
   output logic             gnt_any
);
   always_comb begin
      gnt_any = 1'b0;
      gnt_idx = '0;
      // walk from the farthest slot back to ptr so the nearest valid channel wins
      for (int k = N_CH - 1; k >= 0; k--) begin
         int j;
         j = int'(ptr) + k;
         j = (j >= N_CH) ? j - N_CH : j;
         if (valid[j]) begin
            gnt_any = 1'b1;
            gnt_idx = SEL_W'(j);
         end
      end
      gnt = (en && gnt_any) ? (N_CH'(1) << gnt_idx) : '0;
   end
endmodule

// File: rtl/rr_arb_mux.sv
// rr_arb_mux: round-robin N-channel stream mux into a one-entry output register
// RR_ARB_MUX_STATS_EN adds a saturating 16-bit xfer_cnt of output transfers
module rr_arb_mux
   import rr_arb_mux_pkg::*;
#(
   parameter int N_CH = N_CH_DEF,
   parameter int DATA_W = DATA_W_DEF,
   localparam int SEL_W = $clog2(N_CH)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [N_CH-1:0]        in_valid,
   input  logic [N_CH*DATA_W-1:0] in_data,
   output logic [N_CH-1:0]        in_ready,
   output logic                   out_valid,
   output logic [DATA_W-1:0]      out_data,
   output logic [SEL_W-1:0]       out_sel,
   input  logic                   out_ready
`ifdef RR_ARB_MUX_STATS_EN
   ,
   output logic [STATS_W-1:0]     xfer_cnt
`endif
);
   logic [SEL_W-1:0] ptr;
   logic [SEL_W-1:0] gnt_idx;
   logic             gnt_any;
   logic             load_en;
   logic             xfer;

   // rst_n gates the arbiter so no ready leaks out while held in reset
   assign load_en = (!out_valid || out_ready) && rst_n;
   assign xfer = gnt_any && load_en;

   rr_arbiter #(.N_CH(N_CH)) u_arb (
      .valid   (in_valid),
      .ptr     (ptr),
      .en      (load_en),
      .gnt     (in_ready),
      .gnt_idx (gnt_idx),
      .gnt_any (gnt_any)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data <= '0;
         out_sel <= '0;
         ptr <= '0;
      end else if (xfer) begin
         out_valid <= 1'b1;
         out_data <= in_data[gnt_idx*DATA_W +: DATA_W];
         out_sel <= gnt_idx;
         ptr <= SEL_W'(next_ptr(int'(gnt_idx), N_CH));
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

`ifdef RR_ARB_MUX_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) xfer_cnt <= '0;
      else if (out_valid && out_ready && xfer_cnt != STATS_MAX) xfer_cnt <= xfer_cnt + 1'b1;
   end
`endif
endmodule

// File: tb/tb_rr_arb_mux.sv
// tb_rr_arb_mux: directed and randomized checks of rr_arb_mux against a queue-free behavioural model
module tb_rr_arb_mux;
   localparam int N = 4;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [N-1:0] in_valid = '0;
   logic [N*8-1:0] in_data = '0;
   logic [N-1:0] in_ready;
   logic out_valid;
   logic [7:0] out_data;
   logic [1:0] out_sel;
   logic out_ready = 1'b0;
`ifdef RR_ARB_MUX_STATS_EN
   logic [15:0] xfer_cnt;
`endif

   rr_arb_mux #(.N_CH(N), .DATA_W(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_sel   (out_sel),
      .out_ready (out_ready)
`ifdef RR_ARB_MUX_STATS_EN
      ,
      .xfer_cnt  (xfer_cnt)
`endif
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;
   int mptr = 0;
   logic mv = 1'b0;
   logic [7:0] md = '0;
   int ms = 0;
   logic [15:0] mcnt = '0;
   logic [N-1:0] lr = '0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      mptr = 0; mv = 1'b0; md = '0; ms = 0; mcnt = '0; lr = '0;
   endtask

   task automatic chk_outs();
      chk("out_valid", 32'(out_valid), 32'(mv));
      chk("out_data", 32'(out_data), 32'(md));
      chk("out_sel", 32'(out_sel), ms);
      chk("ptr", 32'(dut.ptr), mptr);
`ifdef RR_ARB_MUX_STATS_EN
      chk("xfer_cnt", 32'(xfer_cnt), 32'(mcnt));
`endif
   endtask

   // called just after a negedge with inputs already driven
   task automatic cycle();
      int g;
      logic [N-1:0] er;
      #1;
      g = -1;
      for (int k = 0; k < N; k++) begin
         int c;
         c = (mptr + k) % N;
         if (g < 0 && in_valid[c]) g = c;
      end
      er = (g >= 0 && (!mv || out_ready)) ? N'(1 << g) : '0;
      chk("in_ready", 32'(in_ready), 32'(er));
      @(posedge clk);
      if (mv && out_ready && mcnt != 16'hFFFF) mcnt++;
      if (er != 0) begin
         mv = 1'b1; md = in_data[g*8 +: 8]; ms = g; mptr = (g + 1) % N;
      end else if (out_ready) mv = 1'b0;
      lr = er;
      #1;
      chk_outs();
      @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      model_reset();
      chk_outs();
      chk("rst_in_ready", 32'(in_ready), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      // reset with every channel requesting
      in_valid = 4'hF;
      in_data = {8'h43, 8'h32, 8'h21, 8'h10};
      out_ready = 1'b1;
      do_reset();
      cycle();
      chk("first_grant", 32'(out_sel), 32'h0);
      // single channel
      do_reset();
      in_valid = 4'b0100;
      in_data = {8'h00, 8'hA5, 8'h00, 8'h00};
      cycle();
      chk("single_data", 32'(out_data), 32'hA5);
      chk("single_ptr", 32'(dut.ptr), 32'd3);
      // rotation with continuous traffic
      do_reset();
      in_valid = 4'hF;
      in_data = {8'h43, 8'h32, 8'h21, 8'h10};
      for (int i = 0; i < 8; i++) begin
         cycle();
         chk("rot_sel", 32'(out_sel), i % N);
      end
      // backpressure while holding 8'h21
      do_reset();
      cycle();
      cycle();
      chk("bp_hold", 32'(out_data), 32'h21);
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) cycle();
      chk("bp_stable", 32'(out_data), 32'h21);
      out_ready = 1'b1;
      cycle();
      chk("bp_reload", 32'(out_sel), 32'd2);
      // wrap and skip from ptr=3
      do_reset();
      in_valid = 4'b0100;
      cycle();
      in_valid = 4'b1010;
      cycle();
      chk("wrap_sel", 32'(out_sel), 32'd3);
      chk("wrap_ptr", 32'(dut.ptr), 32'd0);
      in_valid = 4'b0010;
      cycle();
      chk("skip_sel", 32'(out_sel), 32'd1);
      chk("skip_ptr", 32'(dut.ptr), 32'd2);
      // asynchronous reset between edges while holding 8'h43
      in_valid = 4'b1000;
      cycle();
      chk("pre_rst_data", 32'(out_data), 32'h43);
      in_valid = '0;
      #2 rst_n = 1'b0;
      #1;
      chk("async_valid", 32'(out_valid), 32'h0);
      chk("async_ptr", 32'(dut.ptr), 32'h0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      in_valid = 4'hF;
      for (int i = 0; i < 6; i++) cycle();
`ifdef RR_ARB_MUX_STATS_EN
      chk("cnt_five", 32'(xfer_cnt), 32'd5);
`endif
      // randomized traffic honouring the hold-until-ready rule
      for (int t = 0; t < 500; t++) begin
         out_ready = ($urandom % 4) != 0;
         for (int i = 0; i < N; i++)
            if (!(in_valid[i] && !lr[i])) begin
               in_valid[i] = ($urandom % 3) != 0;
               in_data[i*8 +: 8] = 8'($urandom);
            end
         cycle();
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
